// File: rtl/seq_subtractor_nbit.sv
// seq_subtractor_nbit
// Multi-cycle N-bit subtractor: diff = a - b - bin (mod 2^N), processed K bits
// per clock from LSB to MSB, so one operation takes N/K RUN cycles.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   a, b, bin              minuend, subtrahend, borrow-in
//   in_valid / in_ready    operand handshake (in_ready only in IDLE)
//   diff, bout, ovf        registered result, final borrow, signed overflow
//   out_valid / out_ready  result handshake (out_valid only in DONE)
module seq_subtractor_nbit #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int NCH = N / K;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_bad_param
      $error("seq_subtractor_nbit: K must satisfy 1 <= K <= N and divide N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   wdiff_q;
  logic           borrow_q;
  logic [N-1:0]   diff_q;
  logic           bout_q;
  logic           ovf_q;

  logic [K-1:0]   a_chunk;
  logic [K-1:0]   b_chunk;
  logic [K:0]     sub_w;
  logic [N-1:0]   wdiff_d;
  logic           ovf_d;
  logic           last_w;
  int             idx;

  // Chunk datapath: one K-bit slice per RUN cycle. The extra top bit of the
  // K+1-bit difference goes to 1 exactly when the slice result is negative,
  // which is the borrow into the next slice.
  always_comb begin
    idx     = int'(cnt_q) * K;
    a_chunk = a_q[idx +: K];
    b_chunk = b_q[idx +: K];
    sub_w   = {1'b0, a_chunk} - {1'b0, b_chunk} - {{K{1'b0}}, borrow_q};
    wdiff_d = wdiff_q;
    wdiff_d[idx +: K] = sub_w[K-1:0];
    // Overflow only possible when operand signs differ; then the result must
    // keep the minuend's sign.
    ovf_d   = (a_q[N-1] ^ b_q[N-1]) & (wdiff_d[N-1] ^ a_q[N-1]);
    last_w  = (cnt_q == CW'(NCH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wdiff_q  <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            wdiff_q  <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          wdiff_q  <= wdiff_d;
          borrow_q <= sub_w[K];
          cnt_q    <= cnt_q + 1'b1;
          if (last_w) begin
            // Output registers only change here, so they hold the previous
            // result through IDLE and RUN of the next operation.
            diff_q  <= wdiff_d;
            bout_q  <= sub_w[K];
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_subtractor_nbit.sv
// Testbench for seq_subtractor_nbit (N=32, K=8): table-driven vectors,
// random vectors against a full-width reference, backpressure and
// asynchronous reset sequences. Results are checked through a scoreboard
// queue filled at acceptance and drained at transfer.
module tb_seq_subtractor_nbit;

  localparam int N   = 32;
  localparam int K   = 8;
  localparam int NCH = N / K;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  seq_subtractor_nbit #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin),
    .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .bout(bout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Independent full-width reference for random vectors.
  function automatic res_t ref_sub(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbi);
    res_t r;
    logic [N:0] w;
    w    = {1'b0, ta} - {1'b0, tb} - {{N{1'b0}}, tbi};
    r.d  = w[N-1:0];
    r.bo = w[N];
    r.ov = (ta[N-1] != tb[N-1]) && (r.d[N-1] != ta[N-1]);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic accept(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbi,
                        input res_t e);
    int guard;
    a = ta; b = tb; bin = tbi; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 64'd0, 64'd1);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
  endtask

  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(NCH));
  endtask

  task automatic take_result(input int hold);
    logic [N-1:0] d0;
    logic         b0, o0;
    res_t         e;
    d0 = diff; b0 = bout; o0 = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_stable", {31'd0, b0, o0, d0}, {31'd0, bout, ovf, diff});
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("diff", 64'(diff), 64'(e.d));
      chk("bout", 64'(bout), 64'(e.bo));
      chk("ovf",  64'(ovf),  64'(e.ov));
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready",  64'(in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    res_t e;
    logic [N-1:0] ra, rb;
    logic         rbi;
    logic [N-1:0] d0;

    vt[0] = '{32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0};
    vt[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vt[4] = '{32'h00000100, 32'h000000FF, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vt[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[6] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff",      64'(diff),      64'd0);
    chk("rst_bout",      64'(bout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, back to back.
    for (int i = 0; i < 7; i++) begin
      e = '{vt[i].d, vt[i].bo, vt[i].ov};
      accept(vt[i].a, vt[i].b, vt[i].bi, e);
      wait_valid();
      take_result(i % 3);
    end

    // Random vectors against the full-width reference.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rbi = 1'($urandom);
      if (i == 0) ra = 32'hFFFFFFFF;
      accept(ra, rb, rbi, ref_sub(ra, rb, rbi));
      wait_valid();
      take_result($urandom_range(0, 2));
    end

    // Backpressure: result held for 5 cycles while a new operand waits.
    accept(32'h00001000, 32'h00000001, 1'b0, '{32'h00000FFF, 1'b0, 1'b0});
    wait_valid();
    d0 = diff;
    a = 32'h00000020; b = 32'h00000030; bin = 1'b0; in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_valid",    64'(out_valid), 64'd1);
      chk("bp_diff",     64'(diff),      64'(d0));
      chk("bp_in_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    chk("bp_result_diff", 64'(diff), 64'(e.d));
    chk("bp_result_bout", 64'(bout), 64'(e.bo));
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready),  64'd1);
    chk("bp_release_valid",    64'(out_valid), 64'd0);
    accept(32'h00000020, 32'h00000030, 1'b0, '{32'hFFFFFFF0, 1'b1, 1'b0});
    wait_valid();
    take_result(0);

    // Asynchronous reset in the middle of RUN discards the operation.
    accept(32'h00000009, 32'h00000002, 1'b0, '{32'h00000007, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_diff",      64'(diff),      64'd0);
    chk("arst_bout",      64'(bout),      64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    accept(32'h00000005, 32'h00000009, 1'b0, '{32'hFFFFFFFC, 1'b1, 1'b0});
    wait_valid();
    take_result(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
